// File: rtl/uart_tx_gen.sv
// uart_tx_gen: UART transmitter with a small TX FIFO, configurable framing and
// per-sixteenth-slot glitch injection for exercising receivers.
//
// Ports
//   clk            system clock, everything on the rising edge
//   rstn           synchronous active-low reset
//   tx_en          allows a new frame to start
//   baud_rate      clocks per bit: [15:4] clocks per sixteenth slot, [3:0] extra clocks after slot 15
//   data_len       data bits per frame (clamped to 5..9)
//   parity_en      parity bit present
//   parity_type    0 even, 1 odd
//   stop_len       00:1, 01:0.5, 10:2, 11:1.5 stop bits
//   wr_vld/wr_data FIFO push request and word (LSB sent first)
//   wr_rdy         FIFO not full
//   noise_en       enables glitch injection
//   noise_mask     bit k inverts the line during sixteenth slot k
//   parity_err_inj inverts the transmitted parity bit
//   tx_dout        serial line, idle high
//   tx_busy        high whenever the FSM is not idle
//   tx_done_p      one-clock pulse on the last clock of the stop period
//   fifo_cnt       words held in the FIFO
//   tx_state       IDLE=0, START=1, DATA=2, PARITY=3, STOP=4
module uart_tx_gen #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   tx_en,
    input  logic [15:0]            baud_rate,
    input  logic [3:0]             data_len,
    input  logic                   parity_en,
    input  logic                   parity_type,
    input  logic [1:0]             stop_len,
    input  logic                   wr_vld,
    input  logic [8:0]             wr_data,
    output logic                   wr_rdy,
    input  logic                   noise_en,
    input  logic [15:0]            noise_mask,
    input  logic                   parity_err_inj,
    output logic                   tx_dout,
    output logic                   tx_busy,
    output logic                   tx_done_p,
    output logic [$clog2(DEPTH):0] fifo_cnt,
    output logic [2:0]             tx_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // XOR of the low len bits of d
    function automatic logic data_parity(input logic [8:0] d, input logic [3:0] len);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < int'(len)) begin
                p = p ^ d[i];
            end else begin
                p = p;
            end
        end
        return p;
    endfunction

    state_t         state_r, state_nxt_s;
    logic [8:0]     mem_r [DEPTH];
    logic [AW-1:0]  wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]  cnt_r, cnt_nxt_s;
    logic           wr_rdy_r;
    logic [8:0]     data_r, data_nxt_s;
    logic           par_en_r, par_en_nxt_s;
    logic           par_bit_r, par_bit_nxt_s;
    logic [3:0]     len_r, len_nxt_s;
    logic [3:0]     bit_idx_r, bit_idx_nxt_s;
    logic [11:0]    slot_len_r, slot_len_nxt_s;
    logic [3:0]     frac_r, frac_nxt_s;
    logic [3:0]     slot_r, slot_nxt_s;
    logic [11:0]    sub_r, sub_nxt_s;
    logic           in_frac_r, in_frac_nxt_s;
    logic [16:0]    stop_tot_r, stop_tot_nxt_s;
    logic [16:0]    stop_cnt_r, stop_cnt_nxt_s;
    logic           noise_en_r, noise_en_nxt_s;
    logic [15:0]    mask_r, mask_nxt_s;
    logic           tx_dout_r, tx_busy_r, tx_done_r;

    logic [15:0]    baud_c_s;
    logic [3:0]     len_c_s;
    logic [16:0]    stop_tot_c_s;
    logic           push_s, load_s, start_ok_s, bit_end_s;
    logic           line_bit_s, noisy_s, dout_nxt_s, busy_nxt_s, done_nxt_s;

    // Clamp the live configuration inputs into the values a new frame latches
    always_comb begin
        if (baud_rate < 16'd16) begin
            baud_c_s = 16'd16;
        end else begin
            baud_c_s = baud_rate;
        end
        if (data_len < 4'd5) begin
            len_c_s = 4'd5;
        end else if (data_len > 4'd9) begin
            len_c_s = 4'd9;
        end else begin
            len_c_s = data_len;
        end
        case (stop_len)
            2'b00:   stop_tot_c_s = {1'b0, baud_c_s};
            2'b01:   stop_tot_c_s = {2'b00, baud_c_s[15:1]};
            2'b10:   stop_tot_c_s = {baud_c_s, 1'b0};
            2'b11:   stop_tot_c_s = {1'b0, baud_c_s} + {2'b00, baud_c_s[15:1]};
            default: stop_tot_c_s = {1'b0, baud_c_s};
        endcase
    end

    // Frame FSM, bit timing and next values of the registered outputs
    always_comb begin
        state_nxt_s    = state_r;
        data_nxt_s     = data_r;
        par_en_nxt_s   = par_en_r;
        par_bit_nxt_s  = par_bit_r;
        len_nxt_s      = len_r;
        bit_idx_nxt_s  = bit_idx_r;
        slot_len_nxt_s = slot_len_r;
        frac_nxt_s     = frac_r;
        slot_nxt_s     = slot_r;
        sub_nxt_s      = sub_r;
        in_frac_nxt_s  = in_frac_r;
        stop_tot_nxt_s = stop_tot_r;
        stop_cnt_nxt_s = stop_cnt_r;
        noise_en_nxt_s = noise_en_r;
        mask_nxt_s     = mask_r;
        load_s         = 1'b0;
        start_ok_s     = tx_en && (cnt_r != {CW{1'b0}});
        push_s         = wr_vld && wr_rdy_r;

        // A bit ends after slot 15, or after the extra clocks when there are any
        if (in_frac_r) begin
            bit_end_s = (sub_r == ({8'd0, frac_r} - 12'd1));
        end else begin
            bit_end_s = (slot_r == 4'd15) && (sub_r == slot_len_r - 12'd1) && (frac_r == 4'd0);
        end

        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    load_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START, ST_DATA, ST_PARITY: begin
                if (bit_end_s) begin
                    slot_nxt_s    = 4'd0;
                    sub_nxt_s     = 12'd0;
                    in_frac_nxt_s = 1'b0;
                    case (state_r)
                        ST_START: begin
                            state_nxt_s   = ST_DATA;
                            bit_idx_nxt_s = 4'd0;
                        end
                        ST_DATA: begin
                            data_nxt_s    = {1'b0, data_r[8:1]};
                            bit_idx_nxt_s = bit_idx_r + 4'd1;
                            if (bit_idx_r == len_r - 4'd1) begin
                                if (par_en_r) begin
                                    state_nxt_s = ST_PARITY;
                                end else begin
                                    state_nxt_s    = ST_STOP;
                                    stop_cnt_nxt_s = 17'd0;
                                end
                            end else begin
                                state_nxt_s = ST_DATA;
                            end
                        end
                        default: begin
                            state_nxt_s    = ST_STOP;
                            stop_cnt_nxt_s = 17'd0;
                        end
                    endcase
                end else if (in_frac_r) begin
                    sub_nxt_s = sub_r + 12'd1;
                end else if (sub_r == slot_len_r - 12'd1) begin
                    sub_nxt_s = 12'd0;
                    if (slot_r == 4'd15) begin
                        in_frac_nxt_s = 1'b1;
                    end else begin
                        slot_nxt_s = slot_r + 4'd1;
                    end
                end else begin
                    sub_nxt_s = sub_r + 12'd1;
                end
            end
            ST_STOP: begin
                if (stop_cnt_r == stop_tot_r - 17'd1) begin
                    if (start_ok_s) begin
                        load_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    stop_cnt_nxt_s = stop_cnt_r + 17'd1;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase

        // Frame start: pop the head and freeze the whole configuration
        if (load_s) begin
            state_nxt_s    = ST_START;
            data_nxt_s     = mem_r[rd_ptr_r];
            par_en_nxt_s   = parity_en;
            par_bit_nxt_s  = data_parity(mem_r[rd_ptr_r], len_c_s) ^ parity_type ^ parity_err_inj;
            len_nxt_s      = len_c_s;
            bit_idx_nxt_s  = 4'd0;
            slot_len_nxt_s = baud_c_s[15:4];
            frac_nxt_s     = baud_c_s[3:0];
            slot_nxt_s     = 4'd0;
            sub_nxt_s      = 12'd0;
            in_frac_nxt_s  = 1'b0;
            stop_tot_nxt_s = stop_tot_c_s;
            stop_cnt_nxt_s = 17'd0;
            noise_en_nxt_s = noise_en;
            mask_nxt_s     = noise_mask;
        end else begin
            state_nxt_s = state_nxt_s;
        end

        case ({push_s, load_s})
            2'b10:   cnt_nxt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   cnt_nxt_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
            default: cnt_nxt_s = cnt_r;
        endcase

        case (state_nxt_s)
            ST_START:  line_bit_s = 1'b0;
            ST_DATA:   line_bit_s = data_nxt_s[0];
            ST_PARITY: line_bit_s = par_bit_nxt_s;
            default:   line_bit_s = 1'b1;
        endcase
        // The extra clocks keep slot 15, including its glitch
        noisy_s = noise_en_nxt_s && mask_nxt_s[slot_nxt_s] &&
                  ((state_nxt_s == ST_START) || (state_nxt_s == ST_DATA) || (state_nxt_s == ST_PARITY));
        dout_nxt_s = line_bit_s ^ noisy_s;
        busy_nxt_s = (state_nxt_s != ST_IDLE);
        done_nxt_s = (state_nxt_s == ST_STOP) && (stop_cnt_nxt_s == stop_tot_nxt_s - 17'd1);
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // State, counters, latched frame configuration and registered outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r    <= ST_IDLE;
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            cnt_r      <= {CW{1'b0}};
            wr_rdy_r   <= 1'b1;
            data_r     <= 9'd0;
            par_en_r   <= 1'b0;
            par_bit_r  <= 1'b0;
            len_r      <= 4'd0;
            bit_idx_r  <= 4'd0;
            slot_len_r <= 12'd0;
            frac_r     <= 4'd0;
            slot_r     <= 4'd0;
            sub_r      <= 12'd0;
            in_frac_r  <= 1'b0;
            stop_tot_r <= 17'd0;
            stop_cnt_r <= 17'd0;
            noise_en_r <= 1'b0;
            mask_r     <= 16'd0;
            tx_dout_r  <= 1'b1;
            tx_busy_r  <= 1'b0;
            tx_done_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (load_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            cnt_r      <= cnt_nxt_s;
            wr_rdy_r   <= (cnt_nxt_s != FULL_C);
            data_r     <= data_nxt_s;
            par_en_r   <= par_en_nxt_s;
            par_bit_r  <= par_bit_nxt_s;
            len_r      <= len_nxt_s;
            bit_idx_r  <= bit_idx_nxt_s;
            slot_len_r <= slot_len_nxt_s;
            frac_r     <= frac_nxt_s;
            slot_r     <= slot_nxt_s;
            sub_r      <= sub_nxt_s;
            in_frac_r  <= in_frac_nxt_s;
            stop_tot_r <= stop_tot_nxt_s;
            stop_cnt_r <= stop_cnt_nxt_s;
            noise_en_r <= noise_en_nxt_s;
            mask_r     <= mask_nxt_s;
            tx_dout_r  <= dout_nxt_s;
            tx_busy_r  <= busy_nxt_s;
            tx_done_r  <= done_nxt_s;
        end
    end

    assign wr_rdy    = wr_rdy_r;
    assign tx_dout   = tx_dout_r;
    assign tx_busy   = tx_busy_r;
    assign tx_done_p = tx_done_r;
    assign fifo_cnt  = cnt_r;
    assign tx_state  = state_r;

endmodule

// File: tb/tb_uart_tx_gen.sv
// Self-checking bench for uart_tx_gen: table of whole-frame vectors with
// hand-computed line bits, plus directed FIFO, back-to-back and reset sequences.
module tb_uart_tx_gen;

    logic        clk;
    logic        rstn;
    logic        tx_en;
    logic [15:0] baud_rate;
    logic [3:0]  data_len;
    logic        parity_en;
    logic        parity_type;
    logic [1:0]  stop_len;
    logic        wr_vld;
    logic [8:0]  wr_data;
    logic        wr_rdy;
    logic        noise_en;
    logic [15:0] noise_mask;
    logic        parity_err_inj;
    logic        tx_dout;
    logic        tx_busy;
    logic        tx_done_p;
    logic [2:0]  fifo_cnt;
    logic [2:0]  tx_state;

    int checks = 0;
    int failures = 0;

    uart_tx_gen #(.DEPTH(4)) dut (
        .clk(clk), .rstn(rstn), .tx_en(tx_en), .baud_rate(baud_rate),
        .data_len(data_len), .parity_en(parity_en), .parity_type(parity_type),
        .stop_len(stop_len), .wr_vld(wr_vld), .wr_data(wr_data), .wr_rdy(wr_rdy),
        .noise_en(noise_en), .noise_mask(noise_mask), .parity_err_inj(parity_err_inj),
        .tx_dout(tx_dout), .tx_busy(tx_busy), .tx_done_p(tx_done_p),
        .fifo_cnt(fifo_cnt), .tx_state(tx_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One frame: configuration, data word, expected line bits (bit 0 = start bit)
    typedef struct {
        logic [15:0] baud;
        int          baud_eff;
        logic [3:0]  len;
        logic        par_en;
        logic        par_type;
        logic [1:0]  stop;
        logic        noise;
        logic [15:0] mask;
        logic        perr;
        logic [8:0]  data;
        int          nbits;
        logic [11:0] bits;
        int          stop_clks;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (tx_state == s) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check(name, {31'd0, ok}, 32'd1);
    endtask

    task automatic set_cfg(input logic [15:0] b, input logic [3:0] l, input logic pe,
                           input logic pt, input logic [1:0] sl, input logic ne,
                           input logic [15:0] m, input logic pi);
        baud_rate = b; data_len = l; parity_en = pe; parity_type = pt;
        stop_len = sl; noise_en = ne; noise_mask = m; parity_err_inj = pi;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int errs, serr, dn, done_at, cyc, sl, slot;
        logic e;
        set_cfg(v.baud, v.len, v.par_en, v.par_type, v.stop, v.noise, v.mask, v.perr);
        tx_en   = 1'b0;
        wr_data = v.data;
        wr_vld  = 1'b1;
        @(negedge clk);
        wr_vld = 1'b0;
        tx_en  = 1'b1;
        wait_state(3'd1, 20, $sformatf("v%0d_start", idx));
        // First START clock: drop tx_en and scramble the inputs; the frame must not notice
        tx_en = 1'b0;
        set_cfg(16'd200, 4'd9, ~v.par_en, ~v.par_type, 2'b10, 1'b1, 16'hFFFF, ~v.perr);
        errs = 0; serr = 0; dn = 0; done_at = -1; cyc = 0;
        sl = v.baud_eff / 16;
        for (int b = 0; b < v.nbits; b++) begin
            for (int c = 0; c < v.baud_eff; c++) begin
                slot = (c < 16 * sl) ? (c / sl) : 15;
                e = v.bits[b] ^ (v.noise & v.mask[slot]);
                if (tx_dout !== e) errs++;
                if (tx_done_p === 1'b1) begin dn++; done_at = cyc; end
                cyc++;
                @(negedge clk);
            end
        end
        for (int c = 0; c < v.stop_clks; c++) begin
            if (tx_dout !== 1'b1) serr++;
            if (tx_done_p === 1'b1) begin dn++; done_at = cyc; end
            cyc++;
            @(negedge clk);
        end
        check($sformatf("v%0d_bad_bit_clocks", idx), errs, 0);
        check($sformatf("v%0d_bad_stop_clocks", idx), serr, 0);
        check($sformatf("v%0d_done_pulses", idx), dn, 1);
        check($sformatf("v%0d_done_cycle", idx), done_at, v.nbits * v.baud_eff + v.stop_clks - 1);
        check($sformatf("v%0d_idle_after", idx), {29'd0, tx_state}, 0);
        check($sformatf("v%0d_busy_after", idx), {31'd0, tx_busy}, 0);
    endtask

    initial begin
        int dn, gap, at0, at3, bad;
        // baud, eff, len, pe, pt, stop, noise, mask, perr, data, nbits, bits, stop clocks
        tbl[0] = '{16'd48, 48, 4'd8,  1'b1, 1'b0, 2'b00, 1'b0, 16'h0000, 1'b0, 9'h055, 10, 12'h0AA, 48};
        tbl[1] = '{16'd50, 50, 4'd9,  1'b1, 1'b1, 2'b00, 1'b1, 16'h0100, 1'b0, 9'h1AA, 11, 12'h354, 50};
        tbl[2] = '{16'd16, 16, 4'd8,  1'b1, 1'b0, 2'b00, 1'b0, 16'h0000, 1'b1, 9'h003, 10, 12'h206, 16};
        tbl[3] = '{16'd33, 33, 4'd5,  1'b0, 1'b0, 2'b01, 1'b0, 16'h0000, 1'b0, 9'h00A,  6, 12'h014, 16};
        tbl[4] = '{16'd33, 33, 4'd6,  1'b0, 1'b0, 2'b11, 1'b0, 16'h0000, 1'b0, 9'h02D,  7, 12'h05A, 49};
        tbl[5] = '{16'd5,  16, 4'd3,  1'b1, 1'b1, 2'b10, 1'b0, 16'h0000, 1'b0, 9'h1E3,  7, 12'h046, 32};
        tbl[6] = '{16'd20, 20, 4'd12, 1'b1, 1'b0, 2'b00, 1'b0, 16'h0000, 1'b0, 9'h100, 11, 12'h600, 20};

        rstn = 1'b0; tx_en = 1'b0; wr_vld = 1'b0; wr_data = 9'd0;
        set_cfg(16'd16, 4'd5, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0000, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_dout", {31'd0, tx_dout}, 1);
        check("rst_busy", {31'd0, tx_busy}, 0);
        check("rst_done", {31'd0, tx_done_p}, 0);
        check("rst_state", {29'd0, tx_state}, 0);
        check("rst_cnt", {29'd0, fifo_cnt}, 0);
        check("rst_wr_rdy", {31'd0, wr_rdy}, 1);
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(tbl[i], i);

        // Fill the FIFO with tx_en low; the fifth push is dropped
        set_cfg(16'd16, 4'd5, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0000, 1'b0);
        tx_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wr_data = 9'(k + 1);
            wr_vld  = 1'b1;
            @(negedge clk);
            check($sformatf("fill%0d_cnt", k), {29'd0, fifo_cnt}, (k < 4) ? k + 1 : 4);
            check($sformatf("fill%0d_wr_rdy", k), {31'd0, wr_rdy}, (k < 3) ? 1 : 0);
        end
        wr_vld = 1'b0;

        // Four back-to-back frames of 112 clocks each, no idle clock between them
        tx_en = 1'b1;
        wait_state(3'd1, 5, "b2b_start");
        dn = 0; gap = 0; at0 = -1; at3 = -1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (tx_done_p === 1'b1) begin
                if (dn == 0) at0 = cyc;
                if (dn == 3) at3 = cyc;
                dn++;
            end
            if (tx_state == 3'd0 && dn < 4) gap++;
            if (dn == 4) break;
            @(negedge clk);
        end
        check("b2b_frames", dn, 4);
        check("b2b_idle_clocks", gap, 0);
        check("b2b_first_done", at0, 111);
        check("b2b_last_done", at3, 447);
        @(negedge clk);
        check("b2b_cnt_empty", {29'd0, fifo_cnt}, 0);
        check("b2b_idle", {29'd0, tx_state}, 0);

        // Push into an empty FIFO is not popped in the same clock
        wr_data = 9'h015; wr_vld = 1'b1;
        @(negedge clk);
        wr_vld = 1'b0;
        check("empty_push_cnt", {29'd0, fifo_cnt}, 1);
        check("empty_push_state", {29'd0, tx_state}, 0);
        @(negedge clk);
        check("empty_pop_state", {29'd0, tx_state}, 1);
        check("empty_pop_cnt", {29'd0, fifo_cnt}, 0);
        tx_en = 1'b0;
        wait_state(3'd0, 200, "empty_frame_end");

        // Simultaneous push and pop leaves the count unchanged
        wr_data = 9'h00F; wr_vld = 1'b1;
        @(negedge clk);
        tx_en = 1'b1;
        @(negedge clk);
        wr_vld = 1'b0; tx_en = 1'b0;
        check("pushpop_cnt", {29'd0, fifo_cnt}, 1);
        check("pushpop_state", {29'd0, tx_state}, 1);
        wait_state(3'd0, 200, "pushpop_frame_end");
        repeat (5) @(negedge clk);
        check("no_start_tx_en_low", {29'd0, tx_state}, 0);
        check("held_word_cnt", {29'd0, fifo_cnt}, 1);

        // Reset in the middle of DATA aborts the frame and empties the FIFO
        wr_data = 9'h0F0; wr_vld = 1'b1;
        @(negedge clk);
        wr_vld = 1'b0; tx_en = 1'b1;
        wait_state(3'd2, 60, "rst_reach_data");
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("midrst_dout", {31'd0, tx_dout}, 1);
        check("midrst_state", {29'd0, tx_state}, 0);
        check("midrst_cnt", {29'd0, fifo_cnt}, 0);
        check("midrst_busy", {31'd0, tx_busy}, 0);
        check("midrst_done", {31'd0, tx_done_p}, 0);
        check("midrst_wr_rdy", {31'd0, wr_rdy}, 1);
        rstn = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (tx_state != 3'd0 || tx_done_p !== 1'b0) bad++;
        end
        check("midrst_stays_idle", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
